// File: rtl/mac_pkg.sv
// Shared definitions for the iterative byte-serial multiply-accumulate unit.
package mac_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_8x8_unit.sv
// Combinational 8x8 unsigned multiplier producing a full 16-bit product.
module mult_8x8_unit
    import mac_pkg::*;
(
    input  logic [BYTE_W-1:0]   a,
    input  logic [BYTE_W-1:0]   b,
    output logic [2*BYTE_W-1:0] p
);

    assign p = {{BYTE_W{1'b0}}, a} * {{BYTE_W{1'b0}}, b};

endmodule

// File: rtl/iter_mac_unit.sv
// Iterative unsigned MAC: one shared 8x8 multiplier walks all byte pairs of
// the operands, then the product is added to (or restarts) the accumulator.
module iter_mac_unit
    import mac_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    localparam int K     = WIDTH / BYTE_W;
    localparam int P_W   = 2 * WIDTH;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

    if ((WIDTH % BYTE_W) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
        $error("iter_mac_unit: WIDTH must be a multiple of 8 in 8..64");
    end
    if (ACC_W < 2 * WIDTH) begin : g_bad_acc_w
        $error("iter_mac_unit: ACC_W must be at least 2*WIDTH");
    end

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic             acc_mode;
    logic [P_W-1:0]   product;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [IDX_W-1:0] i_idx, j_idx;

    logic [K-1:0][BYTE_W-1:0] a_bytes, b_bytes;
    logic [2*BYTE_W-1:0]      pp;
    logic [IDX_W:0]           shift_bytes;
    logic [P_W-1:0]           term;
    logic [ACC_W:0]           acc_sum;

    assign a_bytes = a_reg;
    assign b_bytes = b_reg;

    mult_8x8_unit u_mult (
        .a (a_bytes[i_idx]),
        .b (b_bytes[j_idx]),
        .p (pp)
    );

    // Partial product a_byte[i]*b_byte[j] carries weight 2^(8*(i+j)).
    assign shift_bytes = {1'b0, i_idx} + {1'b0, j_idx};
    assign term        = P_W'(pp) << {shift_bytes, 3'b000};
    assign acc_sum     = {1'b0, (acc_mode ? acc : '0)} + {1'b0, ACC_W'(product)};

    assign out_acc = acc;
    assign out_ovf = ovf;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = MUL;
            end
            MUL: begin
                if (i_idx == LAST && j_idx == LAST) state_nxt = ACC;
            end
            ACC: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            acc_mode <= 1'b0;
            product  <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
            i_idx    <= '0;
            j_idx    <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= in_a;
                        b_reg    <= in_b;
                        acc_mode <= in_acc;
                        product  <= '0;
                        i_idx    <= '0;
                        j_idx    <= '0;
                    end
                end
                MUL: begin
                    product <= product + term;
                    if (j_idx == LAST) begin
                        j_idx <= '0;
                        if (i_idx != LAST) i_idx <= i_idx + 1'b1;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                end
                ACC: begin
                    // Sticky across accumulating ops; a restart discards history.
                    acc <= acc_sum[ACC_W-1:0];
                    ovf <= (acc_mode & ovf) | acc_sum[ACC_W];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/iter_mac_unit.md
ITER_MAC_UNIT -- requirements
Module: iter_mac_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; multiple of 8, range 8..64.
REQ-002 SHALL have parameter ACC_W, default 40: accumulator width; ACC_W >= 2*WIDTH, elaboration error otherwise.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept operands.
REQ-007 SHALL have port in_a  input  WIDTH  multiplicand, unsigned.
REQ-008 SHALL have port in_b  input  WIDTH  multiplier, unsigned.
REQ-009 SHALL have port in_acc  input  1  1 = add product to accumulator, 0 = restart accumulator at product.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port out_acc  output  ACC_W  accumulator value.
REQ-013 SHALL have port out_ovf  output  1  sticky accumulator overflow.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> MUL -> ACC -> DONE -> IDLE; K = WIDTH/8.
REQ-016 IDLE: in_ready=1; on edge with in_valid=1, latch in_a, in_b, in_acc, clear product register (2*WIDTH bits), zero byte indices i,j, go MUL.
REQ-017 MUL: each cycle add a_byte[i]*b_byte[j] (16-bit) shifted left 8*(i+j) to product; j increments, wraps to 0 with i incrementing; after K*K cycles go ACC.
REQ-018 ACC: one cycle; acc <= (latched in_acc ? acc : 0) + product, truncated to ACC_W; go DONE.
REQ-019 out_ovf SHALL set on carry out of ACC_W in ACC, stay set while in_acc=1 operations follow, clear at ACC of any operation with in_acc=0 (then set only by that operation's carry).
REQ-020 Latency: acceptance edge E0; out_valid SHALL rise at edge E(K*K+1) (E5 for WIDTH=16, E17 for WIDTH=32).
REQ-021 DONE: out_valid=1; out_acc, out_ovf held stable until edge with out_ready=1, then IDLE.
REQ-022 in_ready SHALL be 0 in MUL, ACC, DONE; in_valid there ignored, operands not captured.
REQ-023 out_ready outside DONE SHALL be ignored.
REQ-024 out_acc SHALL reflect the accumulator register in all states; it changes only at ACC.
REQ-025 Back-to-back: next acceptance SHALL occur no earlier than the edge after DONE exits (throughput one op per K*K+3 cycles minimum).
REQ-026 Operands 0 or all-ones SHALL produce exact results; no saturation.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, acc=0, product=0, out_ovf=0, out_valid=0, busy=0, in_ready=1 after release.
REQ-028 Reset during MUL/ACC/DONE SHALL abort the operation with no result emitted.

Structure
REQ-029 Package mac_pkg SHALL hold the FSM state enumeration and constant BYTE_W=8.
REQ-030 One sub-module mult_8x8_unit (combinational 8x8 unsigned, 16-bit product) SHALL be instantiated once and time-shared across partial products.

Verification
REQ-031 WIDTH=16: 0xFFFF*0xFFFF, in_acc=0 -> out_valid at E5, out_acc=0xFFFE0001, out_ovf=0.
REQ-032 Then 3*4, in_acc=1 -> out_acc=0xFFFE000D; then 2*5, in_acc=0 -> out_acc=0xA.
REQ-033 ACC_W=32, WIDTH=16: 0xFFFF*0xFFFF in_acc=0, then again in_acc=1 -> out_acc=0xFFFC0002, out_ovf=1; then 1*1 in_acc=0 -> out_acc=1, out_ovf=0.
REQ-034 out_ready held low 10 cycles in DONE with in_valid=1 -> out_valid, out_acc stable, in_ready=0, no new operand captured.
REQ-035 rst_n pulsed low at E2 of an operation -> out_valid never asserts, out_acc=0, in_ready=1 after release.
REQ-036 WIDTH=32: 0xFFFFFFFF*2, in_acc=0 -> out_valid at E17, out_acc=0x1FFFFFFFE.
